// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: requests conversions from unsigned_to_bcd, latches the 8-digit
// BCD result and time-multiplexes it onto an 8-digit common-anode 7-seg display.
module bcd_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update,
    input  logic        blank_lz,
    input  logic        conv_idle,
    input  logic [31:0] bcd,
    output logic        conv_trigger,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  an,
    output logic [6:0]  seg
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    // state       | meaning
    // S_IDLE      | waiting for update or a queued request
    // S_REQ       | one-cycle trigger to the converter
    // S_WAIT_BUSY | waiting for the converter to drop idle
    // S_WAIT_DONE | waiting for the converter to raise idle again
    // S_LATCH     | capture bcd into the display register
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_LATCH
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_pending;
    logic             w_pending_next;
    logic             w_trigger;
    logic             w_busy;
    logic [31:0]      r_disp;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             w_wrap;
    logic             w_blank;
    logic [31:0]      w_upper;
    logic [6:0]       w_seg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_trigger      = 1'b0;
        w_busy         = (r_state != S_IDLE);
        if (r_state != S_IDLE && update)
            w_pending_next = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (update || r_pending) begin
                    w_state_next   = S_REQ;
                    w_pending_next = 1'b0;
                end
            end
            S_REQ: begin
                w_trigger    = 1'b1;
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!conv_idle)
                    w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (conv_idle)
                    w_state_next = S_LATCH;
            end
            S_LATCH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp  <= 32'd0;
            r_valid <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_disp  <= bcd;
            r_valid <= 1'b1;
        end
    end

    assign w_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Digits idx..7 shifted down; zero means this digit is a leading zero.
    assign w_upper = r_disp >> {r_idx, 2'b00};
    assign w_blank = !r_valid || (blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0));

    always_comb begin
        w_seg = 7'b1111111;
        if (!w_blank) begin
            case (w_upper[3:0])
                4'd0:    w_seg = 7'b1000000;
                4'd1:    w_seg = 7'b1111001;
                4'd2:    w_seg = 7'b0100100;
                4'd3:    w_seg = 7'b0110000;
                4'd4:    w_seg = 7'b0011001;
                4'd5:    w_seg = 7'b0010010;
                4'd6:    w_seg = 7'b0000010;
                4'd7:    w_seg = 7'b1111000;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0010000;
                default: w_seg = 7'b0111111;
            endcase
        end
    end

    // Anode and segments reload together only at the start of a digit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
        end else if (r_cnt == '0) begin
            r_an  <= ~(8'h01 << r_idx);
            r_seg <= w_seg;
        end
    end

    assign conv_trigger = w_trigger;
    assign busy         = w_busy;
    assign valid        = r_valid;
    assign an           = r_an;
    assign seg          = r_seg;
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner with a scripted stub converter.
module tb_bcd_seg_scanner;
    localparam int DIV = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        update = 1'b0;
    logic        blank_lz = 1'b0;
    logic        conv_idle = 1'b1;
    logic [31:0] bcd = 32'd0;
    logic        conv_trigger;
    logic        busy;
    logic        valid;
    logic [7:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int failures = 0;
    int trig_count = 0;
    logic run_cmp = 1'b0;

    logic [31:0] m_disp = 32'd0;
    logic        m_valid = 1'b0;
    int          t = 0;
    logic [7:0]  exp_an = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;

    bcd_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .update(update),
        .blank_lz(blank_lz),
        .conv_idle(conv_idle),
        .bcd(bcd),
        .conv_trigger(conv_trigger),
        .busy(busy),
        .valid(valid),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pattern for digit d of value v: blank before the first result,
    // blank when every digit from d upward is zero (d>0, blanking on), else decoded.
    function automatic logic [6:0] exp_seg_f(input int d, input logic [31:0] v,
                                             input logic vld, input logic blz);
        logic [31:0] upper;
        upper = v >> (4 * d);
        if (!vld)
            return 7'h7F;
        if (blz && d > 0 && upper == 32'd0)
            return 7'h7F;
        return SEG_TAB[upper[3:0]];
    endfunction

    // Display model: the k-th digit period after reset starts on edge k*DIV and
    // shows digit k mod 8 using the value held just before that edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t       = 0;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
        end else begin
            if (t % DIV == 0) begin
                exp_an  = ~(8'h01 << ((t / DIV) % 8));
                exp_seg = exp_seg_f((t / DIV) % 8, m_disp, m_valid, blank_lz);
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("an", {24'd0, an}, {24'd0, exp_an});
            check("seg", {25'd0, seg}, {25'd0, exp_seg});
            check("valid", {31'd0, valid}, {31'd0, m_valid});
            if (conv_trigger === 1'b1)
                trig_count++;
        end
    end

    task automatic pulse_update;
        @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
        check("trig_latency", {31'd0, conv_trigger}, 32'd1);
        check("busy_on_req", {31'd0, busy}, 32'd1);
    endtask

    // Stub converter: answers the pending trigger, stays busy for `hold` cycles,
    // then presents val with idle high.
    task automatic run_conv(input logic [31:0] val, input int hold);
        int n;
        n = 0;
        while (conv_trigger !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("trig_seen", {31'd0, conv_trigger}, 32'd1);
        @(posedge clk); #1 conv_idle = 1'b0;
        check("trig_one_cycle", {31'd0, conv_trigger}, 32'd0);
        repeat (hold) @(posedge clk);
        #1 bcd = val;
        conv_idle = 1'b1;
        @(posedge clk); #1;
        check("busy_in_latch", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        m_disp  = val;
        m_valid = 1'b1;
        check("busy_after_latch", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_digits(input logic [6:0] lit [8], input string tag);
        int n;
        logic [7:0] want;
        repeat (9 * DIV) @(posedge clk);
        for (int d = 0; d < 8; d++) begin
            want = ~(8'h01 << d);
            n = 0;
            while (an !== want && n < 8 * DIV + 2) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_an"}, {24'd0, an}, {24'd0, want});
            check({tag, "_seg"}, {25'd0, seg}, {25'd0, lit[d]});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] lit [8];
        int tc;

        #1 reset = 1'b0;
        #1 run_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {24'd0, an}, 32'h0000_00FF);
        check("rst_seg", {25'd0, seg}, 32'h0000_007F);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_trig", {31'd0, conv_trigger}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("first_an", {24'd0, an}, 32'h0000_00FE);
        repeat (DIV) @(posedge clk);
        #1 check("second_an", {24'd0, an}, 32'h0000_00FD);
        repeat (DIV) @(posedge clk);
        #1 check("third_an", {24'd0, an}, 32'h0000_00FB);

        // 0xABCD -> 43981 with leading-zero blanking
        blank_lz = 1'b1;
        tc = trig_count;
        pulse_update();
        run_conv(32'h0004_3981, 3);
        repeat (5) @(posedge clk);
        check("one_trigger", trig_count - tc, 32'd1);
        lit = '{7'h79, 7'h00, 7'h10, 7'h30, 7'h19, 7'h7F, 7'h7F, 7'h7F};
        check_digits(lit, "abcd");

        // value 0, no blanking then blanking
        blank_lz = 1'b0;
        pulse_update();
        run_conv(32'h0000_0000, 2);
        lit = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        check_digits(lit, "zero_nb");
        blank_lz = 1'b1;
        lit = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        check_digits(lit, "zero_bl");

        // invalid nibbles
        pulse_update();
        run_conv(32'h0000_F0A5, 4);
        lit = '{7'h12, 7'h3F, 7'h40, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        check_digits(lit, "inval");

        // update held through a conversion queues exactly one more request
        tc = trig_count;
        @(posedge clk); #1 update = 1'b1;
        run_conv(32'h0000_1234, 3);
        update = 1'b0;
        run_conv(32'h0000_0042, 2);
        repeat (20) @(posedge clk);
        #1;
        check("queued_triggers", trig_count - tc, 32'd2);
        check("queued_idle", {31'd0, busy}, 32'd0);

        // reset in WAIT_DONE discards the conversion
        pulse_update();
        @(posedge clk); #1 conv_idle = 1'b0;
        repeat (2) @(posedge clk);
        #2 bcd = 32'h9496_7295;
        reset   = 1'b0;
        m_disp  = 32'd0;
        m_valid = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_trig", {31'd0, conv_trigger}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_an", {24'd0, an}, 32'h0000_00FF);
        check("mid_rst_seg", {25'd0, seg}, 32'h0000_007F);
        conv_idle = 1'b1;
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("no_latch", {31'd0, valid}, 32'd0);
        tc = trig_count;
        blank_lz = 1'b0;
        pulse_update();
        run_conv(32'h9496_7295, 5);
        lit = '{7'h12, 7'h10, 7'h24, 7'h78, 7'h02, 7'h10, 7'h19, 7'h10};
        check_digits(lit, "big");
        check("post_rst_triggers", trig_count - tc, 32'd1);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
